// File: rtl/alu_arbiter_5bit.sv
// alu_arbiter_5bit: round-robin arbiter sharing one combinational ALU between
// two requesters. Operands are registered onto the ALU, held for HOLD_CYCLES,
// then result and flags are captured into a response register with a
// valid/ready handshake.
// Optional feature macro: ALU_ARB_STATS_EN (saturating 16-bit grant counters
// on gnt_cnt0/gnt_cnt1; when undefined those ports are tied to zero).

module alu_arbiter_5bit #(
  parameter int WIDTH       = 5,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_cf,
  output logic             rsp_sf,
  output logic             rsp_zf,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  if (HOLD_CYCLES < 1) begin : g_hold_check
    $error("alu_arbiter_5bit: HOLD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;          // 0: req0 favoured, 1: req1 favoured
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               id_q, id_d;          // requester of the op in flight
  logic [1:0]         alu_op_q, alu_op_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_z_q, rsp_z_d;
  logic               rsp_cf_q, rsp_cf_d;
  logic               rsp_sf_q, rsp_sf_d;
  logic               rsp_zf_q, rsp_zf_d;
  logic               gnt0, gnt1;

  // Round-robin grant; only offered in IDLE and never while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (req0_valid && (!req1_valid || !rr_q)) gnt0 = 1'b1;
      else if (req1_valid)                      gnt1 = 1'b1;
    end
  end

  // Next-state and register-update logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    rsp_cf_d    = rsp_cf_q;
    rsp_sf_d    = rsp_sf_q;
    rsp_zf_d    = rsp_zf_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          alu_op_d = gnt1 ? req1_op : req0_op;
          alu_a_d  = gnt1 ? req1_a  : req0_a;
          alu_b_d  = gnt1 ? req1_b  : req0_b;
          id_d     = gnt1;
          cnt_d    = CNT_W'(HOLD_CYCLES);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_z_d     = alu_z;
          rsp_cf_d    = alu_cf;
          rsp_sf_d    = alu_sf;
          rsp_zf_d    = alu_zf;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_z_q     <= '0;
      rsp_cf_q    <= 1'b0;
      rsp_sf_q    <= 1'b0;
      rsp_zf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
      rsp_cf_q    <= rsp_cf_d;
      rsp_sf_q    <= rsp_sf_d;
      rsp_zf_q    <= rsp_zf_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_cf     = rsp_cf_q;
  assign rsp_sf     = rsp_sf_q;
  assign rsp_zf     = rsp_zf_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

  // Saturating per-requester accept counters.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (gnt0 && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (gnt1 && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter_5bit.sv
// Testbench for alu_arbiter_5bit: directed scenarios plus randomized traffic,
// a transaction-level reference model and a scoreboard queue drained by an
// independent response monitor. A second instance with HOLD_CYCLES=3 covers
// longer hold timing and reset during EXEC.

module tb_alu_arbiter_5bit;

  localparam int W    = 5;
  localparam int HOLD = 1;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Bench-side ALU standing in for the shared 5-bit ALU: {cf, sf, zf, z}.
  function automatic logic [W+2:0] team_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] w;
    case (op)
      2'b00:   w = {1'b0, a & b};
      2'b01:   w = {1'b0, a | b};
      2'b10:   w = {1'b0, a} + {1'b0, b};
      default: w = {1'b0, a} - {1'b0, b};
    endcase
    return {w[W], w[W-1], (w[W-1:0] == '0), w[W-1:0]};
  endfunction

  // ---------------- main DUT (HOLD_CYCLES = 1) ----------------
  logic reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [1:0] req0_op = 0, req1_op = 0, alu_op;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [W-1:0] alu_a, alu_b, alu_z, rsp_z;
  logic alu_cf, alu_sf, alu_zf;
  logic rsp_valid, rsp_ready = 0, rsp_id, rsp_cf, rsp_sf, rsp_zf;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  assign {alu_cf, alu_sf, alu_zf, alu_z} = team_alu(alu_op, alu_a, alu_b);

  alu_arbiter_5bit #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_z(alu_z), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // ---------------- second DUT (HOLD_CYCLES = 3) ----------------
  logic h_reset = 1'b1;
  logic h_v0 = 0, h_v1 = 0, h_r0, h_r1;
  logic [1:0] h_op0 = 0, h_op1 = 0, h_alu_op;
  logic [W-1:0] h_a0 = 0, h_b0 = 0, h_a1 = 0, h_b1 = 0;
  logic [W-1:0] h_alu_a, h_alu_b, h_alu_z, h_rsp_z;
  logic h_alu_cf, h_alu_sf, h_alu_zf;
  logic h_rsp_valid, h_rsp_ready = 0, h_rsp_id, h_rsp_cf, h_rsp_sf, h_rsp_zf;
  logic [15:0] h_cnt0, h_cnt1;

  assign {h_alu_cf, h_alu_sf, h_alu_zf, h_alu_z} = team_alu(h_alu_op, h_alu_a, h_alu_b);

  alu_arbiter_5bit #(.WIDTH(W), .HOLD_CYCLES(3)) dut_h3 (
    .clk(clk), .reset(h_reset),
    .req0_valid(h_v0), .req0_ready(h_r0), .req0_op(h_op0), .req0_a(h_a0), .req0_b(h_b0),
    .req1_valid(h_v1), .req1_ready(h_r1), .req1_op(h_op1), .req1_a(h_a1), .req1_b(h_b1),
    .alu_op(h_alu_op), .alu_a(h_alu_a), .alu_b(h_alu_b),
    .alu_z(h_alu_z), .alu_cf(h_alu_cf), .alu_sf(h_alu_sf), .alu_zf(h_alu_zf),
    .rsp_valid(h_rsp_valid), .rsp_ready(h_rsp_ready), .rsp_id(h_rsp_id), .rsp_z(h_rsp_z),
    .rsp_cf(h_rsp_cf), .rsp_sf(h_rsp_sf), .rsp_zf(h_rsp_zf),
    .gnt_cnt0(h_cnt0), .gnt_cnt1(h_cnt1)
  );

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic         id;
    logic [1:0]   op;
    logic [W-1:0] a, b, z;
    logic         cf, sf, zf;
    int           acc;   // cycle the request was presented (accept edge follows)
    int           due;   // first cycle rsp_valid must be visible
  } exp_t;

  exp_t q[$];
  bit   m_idle = 1'b1;
  bit   m_rr   = 1'b0;
  bit   m_id   = 1'b0;
  int   m_due  = 0;
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;

  // Expected response from the operation definitions in plain integer arithmetic.
  function automatic exp_t predict(input logic id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int r;
    case (op)
      2'd0:    r = int'(a & b);
      2'd1:    r = int'(a | b);
      2'd2:    r = int'(a) + int'(b);
      default: r = int'(a) - int'(b);
    endcase
    e.id  = id;
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.z   = W'(r & MASK);
    e.cf  = (op == 2'd2) ? (r > MASK) : (op == 2'd3) ? (r < 0) : 1'b0;
    e.sf  = ((r & MASK) >= (1 << (W - 1)));
    e.zf  = ((r & MASK) == 0);
    e.acc = 0;
    e.due = 0;
    return e;
  endfunction

  // One clock of stimulus: drive inputs, check grants against the model, record accepts.
  task automatic drive_cycle(input bit v0, input logic [1:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                             input bit v1, input logic [1:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                             input bit rdy);
    bit e0, e1;
    exp_t item;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready  = rdy;
    #1;
    e0 = m_idle && v0 && (!v1 || !m_rr);
    e1 = m_idle && v1 && (!v0 || m_rr);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    if (e0 || e1) begin
      item     = e1 ? predict(1'b1, o1, a1, b1) : predict(1'b0, o0, a0, b0);
      item.acc = cyc;
      item.due = cyc + 1 + HOLD;
      q.push_back(item);
      m_idle = 1'b0;
      m_id   = e1;
      m_due  = item.due;
      if (e1) m_cnt1++; else m_cnt0++;
    end else if (!m_idle && cyc >= m_due && rdy) begin
      m_idle = 1'b1;
      m_rr   = !m_id;
    end
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive_cycle(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, rdy);
  endtask

  // Reset the main DUT (optionally with both valids high) and check every output is cleared.
  task automatic do_reset(input bit valids_high);
    @(negedge clk);
    reset = 1'b1;
    req0_valid = valids_high; req1_valid = valids_high; rsp_ready = 1'b0;
    q.delete();
    m_idle = 1'b1; m_rr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", {rsp_id, rsp_z, rsp_cf, rsp_sf, rsp_zf}, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("rst_gnt_cnt", {gnt_cnt0, gnt_cnt1}, 0);
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Response monitor: rsp_valid timing, held operands and response contents.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        exp_v = (q.size() > 0) && (cyc >= q[0].due);
        check("rsp_valid", rsp_valid, exp_v);
        if (q.size() > 0 && cyc > q[0].acc)
          check("alu_hold", {alu_op, alu_a, alu_b}, {q[0].op, q[0].a, q[0].b});
        if (rsp_valid && exp_v) begin
          check("rsp_id", rsp_id, q[0].id);
          check("rsp_z", rsp_z, q[0].z);
          check("rsp_flags", {rsp_cf, rsp_sf, rsp_zf}, {q[0].cf, q[0].sf, q[0].zf});
          if (rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    do_reset(1'b1);

    // req0 AND 10101 & 01100 -> 00100, response one cycle after accept
    drive_cycle(1, 2'd0, 5'b10101, 5'b01100, 0, 2'd0, '0, '0, 1);
    idle_cycles(3, 1);

    // Both valid: req0 ADD 3+4, req1 OR 16|1, alternating round-robin service
    for (int i = 0; i < 12; i++)
      drive_cycle(1, 2'd2, 5'b00011, 5'b00100, 1, 2'd1, 5'b10000, 5'b00001, 1);
    idle_cycles(3, 1);

    // req1 AND 11100 & 00000 -> zero flag
    drive_cycle(0, 2'd0, '0, '0, 1, 2'd0, 5'b11100, 5'b00000, 1);
    idle_cycles(3, 1);

    // Consumer stalls in RESP with both requesters waiting
    drive_cycle(1, 2'd3, 5'b00010, 5'b00101, 0, 2'd0, '0, '0, 0);
    for (int i = 0; i < 4; i++)
      drive_cycle(1, 2'd2, 5'b11111, 5'b00001, 1, 2'd3, 5'b00000, 5'b00000, 0);
    drive_cycle(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, 1);
    idle_cycles(3, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      drive_cycle($urandom_range(0, 1), 2'($urandom), W'($urandom), W'($urandom),
                  $urandom_range(0, 1), 2'($urandom), W'($urandom), W'($urandom),
                  ($urandom_range(0, 3) != 0));
    idle_cycles(6, 1);
    check("queue_drained", q.size(), 0);
`ifdef ALU_ARB_STATS_EN
    check("gnt_cnt0", gnt_cnt0, m_cnt0);
    check("gnt_cnt1", gnt_cnt1, m_cnt1);
`else
    check("gnt_cnt0_tied", gnt_cnt0, 0);
    check("gnt_cnt1_tied", gnt_cnt1, 0);
`endif

    // Reset during EXEC: serve req0 (pointer moves to req1), start req1, abort it
    do_reset(1'b0);
    drive_cycle(1, 2'd1, 5'b00110, 5'b01001, 0, 2'd0, '0, '0, 1);
    idle_cycles(3, 1);
    drive_cycle(0, 2'd0, '0, '0, 1, 2'd2, 5'b00101, 5'b00101, 1);
    do_reset(1'b1);
    idle_cycles(2, 1);
    drive_cycle(1, 2'd0, 5'b11111, 5'b10101, 1, 2'd1, 5'b00001, 5'b00010, 1);
    idle_cycles(4, 1);
    check("queue_drained_after_reset", q.size(), 0);

    // ---------------- HOLD_CYCLES = 3 instance ----------------
    @(negedge clk);
    h_reset = 1'b0;
    h_v0 = 1; h_op0 = 2'd2; h_a0 = 5'd7; h_b0 = 5'd9; h_rsp_ready = 0;
    #1 check("h3_req0_ready", h_r0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      h_v0 = 0;
      check("h3_rsp_valid_early", h_rsp_valid, 0);
      check("h3_alu_stable", {h_alu_op, h_alu_a, h_alu_b}, {2'd2, 5'd7, 5'd9});
      check("h3_readies_busy", {h_r0, h_r1}, 0);
    end
    @(negedge clk);
    check("h3_rsp_valid", h_rsp_valid, 1);
    check("h3_rsp", {h_rsp_id, h_rsp_z, h_rsp_cf, h_rsp_sf, h_rsp_zf}, {1'b0, 5'd16, 1'b0, 1'b1, 1'b0});
    h_rsp_ready = 1;
    @(negedge clk);
    check("h3_rsp_cleared", h_rsp_valid, 0);
    h_rsp_ready = 0;
    h_v0 = 1; h_v1 = 1; h_op1 = 2'd1; h_a1 = 5'd3; h_b1 = 5'd4;
    #1 check("h3_rr_req1", {h_r0, h_r1}, 2'b01);
    @(negedge clk);
    h_v0 = 0; h_v1 = 0;
    @(negedge clk);
    h_reset = 1; h_v0 = 1; h_v1 = 1;
    @(negedge clk);
    check("h3_rst_readies", {h_r0, h_r1}, 0);
    check("h3_rst_outputs", {h_rsp_valid, h_rsp_id, h_rsp_z, h_rsp_cf, h_rsp_sf, h_rsp_zf, h_alu_op, h_alu_a, h_alu_b}, 0);
    h_reset = 0; h_v0 = 0; h_v1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("h3_no_rsp_after_abort", h_rsp_valid, 0);
    end
    h_v0 = 1; h_v1 = 1;
    #1 check("h3_req0_favoured", {h_r0, h_r1}, 2'b10);
    @(negedge clk);
    h_v0 = 0; h_v1 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_5bit.md
Name: alu_arbiter_5bit

Overview:
Shares one combinational 5-bit ALU (AND/OR/ADD/SUB, with cf/sf/zf flags) between two requesters. Uses round-robin grant and valid/ready handshakes. Registers operands into the ALU, holds them for a fixed number of cycles, then captures result and flags into a response register. Sits between the CPU control unit / address-gen unit and the shared ALU.

Parameters:
WIDTH, 5, operand/result width.
HOLD_CYCLES, 1, cycles operands are held on ALU before capture; must be >= 1 (0 illegal, assert in sim).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 accepted this cycle.
req0_op  input  2  00 AND, 01 OR, 10 ADD, 11 SUB.
req0_a, req0_b  input  WIDTH  operands.
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0.
alu_op  output  2  op to shared ALU.
alu_a, alu_b  output  WIDTH  operands to shared ALU.
alu_z  input  WIDTH  ALU result.
alu_cf, alu_sf, alu_zf  input  1  ALU flags.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer takes response.
rsp_id  output  1  requester served.
rsp_z  output  WIDTH  captured result.
rsp_cf, rsp_sf, rsp_zf  output  1  captured flags.

Behaviour:
- One clock (clk); reset synchronous, active-high. Reset mid-operation aborts in-flight op: no response issued, no grant issued.
- Reset values: state IDLE, rr pointer 0 (req0 favoured), every output 0 (readies, alu_op/a/b, rsp_*).
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational. It is 1 only in IDLE, only for the granted requester, and at most one is high.
  - Grant rule: if only one valid, it wins. If both valid, the rr pointer's requester wins.
  - On a handshake (valid & ready):
    - latch op/a/b into alu_* registers;
    - latch id;
    - load counter with HOLD_CYCLES;
    - go to EXEC.
- EXEC:
  - alu_* stay stable.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1: capture alu_z/cf/sf/zf into rsp_* and rsp_id, set rsp_valid, go to RESP.
- RESP:
  - rsp_valid held with all rsp_* stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid clears at the next edge, rr pointer becomes the other id, and state returns to IDLE.
  - Both req readies are 0 throughout EXEC and RESP.
- Latency: request accepted at edge E implies rsp_valid visible after edge E+HOLD_CYCLES. Earliest next accept is the edge after the response handshake. Throughput with HOLD_CYCLES=1 and rsp_ready tied high is 1 op per 3 cycles.
- alu_* keep their last values in IDLE/RESP (no toggling). rsp_* keep their last values after rsp_valid drops.
- A requester dropping valid before ready gets no transaction. Op/operands sampled only on the handshake edge.
- The block does no arithmetic: width and flag semantics are owned by the ALU and passed through unmodified.

Optional Feature:
ALU_ARB_STATS_EN:
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each).
  - Each increments on its requester's accept handshake.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: ports still present, tied to 0, no counter logic.

Test Plan:
- Bench instantiates the team's 5-bit ALU on alu_*.
- Scenarios:
  - req0 AND a=10101 b=01100, rsp_ready=1 -> rsp_valid 1 cycle after accept, rsp_id=0, rsp_z=00100, zf=0, sf=0.
  - Both valid after reset: req0 ADD 00011+00100, req1 OR 10000|00001 -> req0 served first (z=00111), then req1 (z=10001, sf=1); third simultaneous pair goes to req0 again.
  - req1 AND a=11100 b=00000 -> rsp_z=00000, rsp_zf=1, rsp_id=1.
  - rsp_ready low 3 cycles in RESP -> rsp_valid and rsp_* stable, req0_ready/req1_ready stay 0; release -> IDLE next edge.
  - HOLD_CYCLES=3: accept at edge E -> alu_* stable for 3 cycles, rsp_valid after E+3; reset asserted during EXEC -> no rsp_valid, all outputs 0, req0 favoured next.
  - With ALU_ARB_STATS_EN: 5 req0 and 2 req1 grants -> gnt_cnt0=5, gnt_cnt1=2; reset clears both.
